// File: rtl/sevseg_pkg.sv
// rtl/sevseg_pkg.sv - shared constants and types for the 4-digit 7-segment scanner
package sevseg_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int IDX_W      = $clog2(NUM_DIGITS);

    localparam logic [3:0] OVF_CODE = 4'hF;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000,   // 0
        7'b1111001,   // 1
        7'b0100100,   // 2
        7'b0110000,   // 3
        7'b0011001,   // 4
        7'b0010010,   // 5
        7'b0000010,   // 6
        7'b1111000,   // 7
        7'b0000000,   // 8
        7'b0010000    // 9
    };

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_DRIVE = 1'b1
    } phase_t;

endpackage

// File: rtl/bcd_to_sevseg.sv
// rtl/bcd_to_sevseg.sv - combinational BCD to active-low 7-segment decoder with blank input
module bcd_to_sevseg
    import sevseg_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    // Digits 0-9 get glyphs, the overflow code a dash, every other code stays dark
    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            if (digit <= 4'd9) begin
                seg = SEG_DIGIT[digit];
            end else if (digit == OVF_CODE) begin
                seg = SEG_DASH;
            end
        end
    end

endmodule

// File: rtl/sevseg_scan4.sv
// rtl/sevseg_scan4.sv - 4-digit multiplexed 7-segment driver; SEVSEG_LZB_EN enables leading-zero blanking
module sevseg_scan4
    import sevseg_pkg::*;
#(
    parameter int REFRESH_DIV = 1024,
    parameter int DEAD_CYCLES = 16
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [3:0] BCD0,
    input  logic [3:0] BCD1,
    input  logic [3:0] BCD2,
    input  logic [3:0] BCD3,
    output logic [6:0] Seg,
    output logic       Dp,
    output logic [3:0] An,
    output logic       FrameTick
);

    localparam int               CW         = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0]    CNT_MAX    = CW'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] LAST_DIGIT = IDX_W'(NUM_DIGITS - 1);

    logic [CW-1:0]    slot_cnt;
    logic [IDX_W-1:0] digit_idx;
    logic [15:0]      snap;
    logic             started;

    logic [CW-1:0]    cnt_n;
    logic [IDX_W-1:0] idx_n;
    logic [15:0]      snap_n;
    logic             tick_n;
    phase_t           phase_n;
    logic [3:0]       lz_blank;
    logic [3:0]       digit_n;
    logic [6:0]       seg_dec;
    logic [3:0]       an_n;
    logic [6:0]       seg_n;
    logic [15:0]      bcd_in;

    assign bcd_in = {BCD3, BCD2, BCD1, BCD0};

    // The decimal point is never used by this display
    assign Dp = 1'b1;

    // Next prescaler/digit/snapshot state; the first edge after reset is a frame start at slot_cnt=0
    always_comb begin
        cnt_n  = slot_cnt;
        idx_n  = digit_idx;
        snap_n = snap;
        tick_n = 1'b0;
        if (!started) begin
            cnt_n  = '0;
            idx_n  = '0;
            snap_n = bcd_in;
            tick_n = 1'b1;
        end else if (slot_cnt == CNT_MAX) begin
            cnt_n = '0;
            idx_n = digit_idx + 1'b1;
            if (digit_idx == LAST_DIGIT) begin
                snap_n = bcd_in;
                tick_n = 1'b1;
            end
        end else begin
            cnt_n = slot_cnt + 1'b1;
        end
    end

    // Leading-zero mask over the snapshot that will be on display next cycle
    always_comb begin
        lz_blank = 4'b0000;
`ifdef SEVSEG_LZB_EN
        lz_blank[3] = (snap_n[15:12] == 4'd0);
        lz_blank[2] = lz_blank[3] && (snap_n[11:8] == 4'd0);
        lz_blank[1] = lz_blank[2] && (snap_n[7:4] == 4'd0);
`endif
    end

    // Phase and pin values for the next cycle, so outputs line up with the counters
    always_comb begin
        phase_n = (int'(cnt_n) < DEAD_CYCLES) ? PH_BLANK : PH_DRIVE;
        digit_n = snap_n[{idx_n, 2'b00} +: 4];
        an_n    = 4'b1111;
        seg_n   = SEG_BLANK;
        if (phase_n == PH_DRIVE) begin
            an_n  = ~(4'b0001 << idx_n);
            seg_n = seg_dec;
        end
    end

    bcd_to_sevseg u_dec (
        .digit (digit_n),
        .blank (lz_blank[idx_n]),
        .seg   (seg_dec)
    );

    // Scan state and registered pin outputs
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            slot_cnt  <= '0;
            digit_idx <= '0;
            snap      <= 16'h0000;
            started   <= 1'b0;
            An        <= 4'b1111;
            Seg       <= SEG_BLANK;
            FrameTick <= 1'b0;
        end else begin
            slot_cnt  <= cnt_n;
            digit_idx <= idx_n;
            snap      <= snap_n;
            started   <= 1'b1;
            An        <= an_n;
            Seg       <= seg_n;
            FrameTick <= tick_n;
        end
    end

endmodule

// File: tb/tb_sevseg_scan4.sv
// tb/tb_sevseg_scan4.sv - scoreboard bench for sevseg_scan4 (REFRESH_DIV=8, DEAD_CYCLES=2 and 0)
module tb_sevseg_scan4;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [3:0] BCD0, BCD1, BCD2, BCD3;
    logic [6:0] seg_a, seg_b;
    logic       dp_a, dp_b;
    logic [3:0] an_a, an_b;
    logic       tick_a, tick_b;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       tick;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    sevseg_scan4 #(.REFRESH_DIV(8), .DEAD_CYCLES(2)) dut_a (
        .Clk(Clk), .Reset(Reset),
        .BCD0(BCD0), .BCD1(BCD1), .BCD2(BCD2), .BCD3(BCD3),
        .Seg(seg_a), .Dp(dp_a), .An(an_a), .FrameTick(tick_a)
    );

    sevseg_scan4 #(.REFRESH_DIV(8), .DEAD_CYCLES(0)) dut_b (
        .Clk(Clk), .Reset(Reset),
        .BCD0(BCD0), .BCD1(BCD1), .BCD2(BCD2), .BCD3(BCD3),
        .Seg(seg_b), .Dp(dp_b), .An(an_b), .FrameTick(tick_b)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one expected record per clock, sampled 2 time units after the edge
    always @(posedge Clk) begin
        #2;
        if (q_a.size() > 0) begin
            ea = q_a.pop_front();
            check("a_an",   16'(an_a),   16'(ea.an));
            check("a_seg",  16'(seg_a),  16'(ea.seg));
            check("a_tick", 16'(tick_a), 16'(ea.tick));
            check("a_dp",   16'(dp_a),   16'd1);
        end
        if (q_b.size() > 0) begin
            eb = q_b.pop_front();
            check("b_an",   16'(an_b),   16'(eb.an));
            check("b_seg",  16'(seg_b),  16'(eb.seg));
            check("b_tick", 16'(tick_b), 16'(eb.tick));
            check("b_dp",   16'(dp_b),   16'd1);
        end
    end

    // One 32-cycle frame of expectations; s0..s3 are hand-picked glyphs for digits 0..3
    task automatic push_frame(input bit sel, input int dead,
                              input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3);
        logic [6:0] s [4];
        logic [3:0] one_hot;
        exp_t e;
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        for (int i = 0; i < 4; i++) begin
            for (int c = 0; c < 8; c++) begin
                one_hot = 4'b0001 << i;
                e.an   = (c < dead) ? 4'b1111 : ~one_hot;
                e.seg  = (c < dead) ? 7'b1111111 : s[i];
                e.tick = (i == 0 && c == 0);
                if (sel) q_b.push_back(e);
                else     q_a.push_back(e);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_an_a"},   16'(an_a),   16'hF);
        check({tag, "_seg_a"},  16'(seg_a),  16'h7F);
        check({tag, "_dp_a"},   16'(dp_a),   16'd1);
        check({tag, "_tick_a"}, 16'(tick_a), 16'd0);
        check({tag, "_an_b"},   16'(an_b),   16'hF);
        check({tag, "_seg_b"},  16'(seg_b),  16'h7F);
        check({tag, "_tick_b"}, 16'(tick_b), 16'd0);
    endtask

    // Reset mid-slot, load digits, release, then expect two frames (second may use a new ones digit)
    task automatic scenario(input logic [3:0] d3, input logic [3:0] d2,
                            input logic [3:0] d1, input logic [3:0] d0,
                            input logic [6:0] s3, input logic [6:0] s2,
                            input logic [6:0] s1, input logic [6:0] s0,
                            input bit chg, input logic [3:0] nd0, input logic [6:0] ns0);
        int n;
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        BCD3 = d3; BCD2 = d2; BCD1 = d1; BCD0 = d0;
        repeat (2) @(negedge Clk);
        check_reset_outputs("held_rst");
        Reset = 1'b1;
        push_frame(1'b0, 2, s0, s1, s2, s3);
        push_frame(1'b1, 0, s0, s1, s2, s3);
        push_frame(1'b0, 2, chg ? ns0 : s0, s1, s2, s3);
        push_frame(1'b1, 0, chg ? ns0 : s0, s1, s2, s3);
        if (chg) begin
            repeat (10) @(negedge Clk);
            BCD0 = nd0;
        end
        n = 0;
        while ((q_a.size() > 0 || q_b.size() > 0) && n < 200) begin
            @(negedge Clk);
            n++;
        end
        check("queue_drain", 16'(q_a.size() + q_b.size()), 16'd0);
    endtask

    initial begin
        Reset = 1'b0;
        BCD0 = 4'd0; BCD1 = 4'd0; BCD2 = 4'd0; BCD3 = 4'd0;

        // 1,2,3,4 then ones digit changes 4->9 during slot 1
        scenario(4'd1, 4'd2, 4'd3, 4'd4,
                 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                 1'b1, 4'd9, 7'b0010000);

        // all overflow: dashes everywhere
        scenario(4'hF, 4'hF, 4'hF, 4'hF,
                 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111,
                 1'b0, 4'd0, 7'd0);

`ifdef SEVSEG_LZB_EN
        scenario(4'd0, 4'd0, 4'd4, 4'd2,
                 7'b1111111, 7'b1111111, 7'b0011001, 7'b0100100,
                 1'b0, 4'd0, 7'd0);
        scenario(4'd0, 4'd0, 4'd0, 4'd0,
                 7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000,
                 1'b0, 4'd0, 7'd0);
        scenario(4'd0, 4'hF, 4'd0, 4'd0,
                 7'b1111111, 7'b0111111, 7'b1000000, 7'b1000000,
                 1'b0, 4'd0, 7'd0);
`else
        scenario(4'd0, 4'd0, 4'd4, 4'd2,
                 7'b1000000, 7'b1000000, 7'b0011001, 7'b0100100,
                 1'b0, 4'd0, 7'd0);
        scenario(4'd0, 4'd0, 4'd0, 4'd0,
                 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000,
                 1'b0, 4'd0, 7'd0);
        scenario(4'd0, 4'hF, 4'd0, 4'd0,
                 7'b1000000, 7'b0111111, 7'b1000000, 7'b1000000,
                 1'b0, 4'd0, 7'd0);
`endif

        // code 4'b1011 on digit 0 is dark while its anode stays active
        scenario(4'd8, 4'd7, 4'd6, 4'hB,
                 7'b0000000, 7'b1111000, 7'b0000010, 7'b1111111,
                 1'b0, 4'd0, 7'd0);

        // zeros below a nonzero digit are always shown
        scenario(4'd9, 4'd5, 4'd0, 4'd0,
                 7'b0010000, 7'b0010010, 7'b1000000, 7'b1000000,
                 1'b0, 4'd0, 7'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
